servo_sequencer: RTL and testbench

- Playback sequencer between the servo trajectory ROMs and the three PWM channels.
- Generates the shared ROM address and latches the three 8-bit target positions.
- Slew-limits each channel toward its target on a fixed step tick, then advances to the next address.
- Output mux selects live accelerometer data or playback positions, so the PWM blocks can take either source.

---
 rtl/servo_pkg.sv | 18 +
 rtl/servo_slew.sv | 49 ++++
 rtl/servo_sequencer.sv | 135 +++++++++++++
 tb/tb_servo_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types and constants for the servo playback sequencer.
package servo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    MOVE,
    NEXT
  } state_t;

  localparam logic [7:0] POS_CENTER = 8'h80;

  function automatic int unsigned tick_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/servo_slew.sv
// One slew-limited position channel: latches a target and steps toward it on tick.
import servo_pkg::*;

module servo_slew #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SLEW_MAX   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  load,
  input  logic                  hold,
  input  logic [DATA_WIDTH-1:0] target,
  output logic [DATA_WIDTH-1:0] pos,
  output logic                  at_target
);

  localparam logic signed [DATA_WIDTH:0] SLEW_P = (DATA_WIDTH+1)'(SLEW_MAX);

  logic [DATA_WIDTH-1:0]        target_q;
  logic signed [DATA_WIDTH:0]   diff;
  logic signed [DATA_WIDTH:0]   step;
  logic [DATA_WIDTH-1:0]        pos_step;

  // The clamped step keeps pos+step inside 0..2^W-1, so a W-bit add is exact.
  always_comb begin
    diff = $signed({1'b0, target_q}) - $signed({1'b0, pos});
    if (diff > SLEW_P)       step = SLEW_P;
    else if (diff < -SLEW_P) step = -SLEW_P;
    else                     step = diff;
    pos_step = pos + step[DATA_WIDTH-1:0];
  end

  // Reports whether the position after this tick's step lands on the target.
  assign at_target = (pos_step == target_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= DATA_WIDTH'(POS_CENTER);
      pos      <= DATA_WIDTH'(POS_CENTER);
    end else begin
      if (load)
        target_q <= target;
      if (tick && !hold)
        pos <= pos_step;
    end
  end

endmodule

// File: rtl/servo_sequencer.sv
// Trajectory ROM playback sequencer feeding three PWM channels, with live-data bypass.
import servo_pkg::*;

module servo_sequencer #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned STEP_HZ    = 50,
  parameter int unsigned LAST_ADDR  = 255,
  parameter int unsigned SLEW_MAX   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic                  live_sel,
  input  logic [OUT_WIDTH-1:0]  live_x,
  input  logic [OUT_WIDTH-1:0]  live_y,
  input  logic [OUT_WIDTH-1:0]  live_z,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data_x,
  input  logic [DATA_WIDTH-1:0] rom_data_y,
  input  logic [DATA_WIDTH-1:0] rom_data_z,
  output logic [OUT_WIDTH-1:0]  servo_x,
  output logic [OUT_WIDTH-1:0]  servo_y,
  output logic [OUT_WIDTH-1:0]  servo_z,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned TICK_DIV = CLK_HZ / STEP_HZ;
  localparam int unsigned TW       = tick_width(TICK_DIV);
  localparam int unsigned PAD      = OUT_WIDTH - DATA_WIDTH;

  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic                  done_nx;
  logic                  load;
  logic                  hold;
  logic [2:0]            at_target;
  logic [DATA_WIDTH-1:0] pos_x;
  logic [DATA_WIDTH-1:0] pos_y;
  logic [DATA_WIDTH-1:0] pos_z;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
  end

  always_comb begin
    state_nx = state;
    addr_nx  = rom_address;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        addr_nx = '0;
        if (start && !stop) state_nx = FETCH;
      end
      FETCH: state_nx = LATCH;
      LATCH: state_nx = MOVE;
      MOVE:  if (tick && (&at_target)) state_nx = NEXT;
      NEXT: begin
        state_nx = FETCH;
        if (rom_address < ADDR_WIDTH'(LAST_ADDR)) begin
          addr_nx = rom_address + ADDR_WIDTH'(1);
        end else begin
          addr_nx = '0;
          if (!loop_en) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // Abort overrides every transition above, including the end-of-run pulse.
    if (state != IDLE && stop) begin
      state_nx = IDLE;
      addr_nx  = '0;
      done_nx  = 1'b0;
    end
  end

  assign load = (state == LATCH) && !stop;
  assign hold = (state != MOVE) || stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rom_address <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      rom_address <= addr_nx;
      busy        <= (state_nx != IDLE);
      done        <= done_nx;
    end
  end

  servo_slew #(.DATA_WIDTH(DATA_WIDTH), .SLEW_MAX(SLEW_MAX)) u_slew_x (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .hold(hold),
    .target(rom_data_x), .pos(pos_x), .at_target(at_target[0])
  );

  servo_slew #(.DATA_WIDTH(DATA_WIDTH), .SLEW_MAX(SLEW_MAX)) u_slew_y (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .hold(hold),
    .target(rom_data_y), .pos(pos_y), .at_target(at_target[1])
  );

  servo_slew #(.DATA_WIDTH(DATA_WIDTH), .SLEW_MAX(SLEW_MAX)) u_slew_z (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .hold(hold),
    .target(rom_data_z), .pos(pos_z), .at_target(at_target[2])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      servo_x <= OUT_WIDTH'(POS_CENTER);
      servo_y <= OUT_WIDTH'(POS_CENTER);
      servo_z <= OUT_WIDTH'(POS_CENTER);
    end else begin
      servo_x <= live_sel ? live_x : {{PAD{1'b0}}, pos_x};
      servo_y <= live_sel ? live_y : {{PAD{1'b0}}, pos_y};
      servo_z <= live_sel ? live_z : {{PAD{1'b0}}, pos_z};
    end
  end

endmodule

// File: tb/tb_servo_sequencer.sv
// Directed vector table plus randomized run against a behavioural playback model.
module tb_servo_sequencer;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int OW    = 16;
  localparam int CLKHZ = 100;
  localparam int STEPH = 10;
  localparam int LAST  = 3;
  localparam int SLEW  = 4;
  localparam int TDIV  = CLKHZ / STEPH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic          live_sel = 1'b0;
  logic [OW-1:0] live_x = '0;
  logic [OW-1:0] live_y = '0;
  logic [OW-1:0] live_z = '0;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_data_x, rom_data_y, rom_data_z;
  logic [OW-1:0] servo_x, servo_y, servo_z;
  logic          busy, done;

  logic [DW-1:0] rom [3][0:LAST];

  assign rom_data_x = rom[0][rom_address[1:0]];
  assign rom_data_y = rom[1][rom_address[1:0]];
  assign rom_data_z = rom[2][rom_address[1:0]];

  always #5 clk = ~clk;

  servo_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .CLK_HZ(CLKHZ),
    .STEP_HZ(STEPH), .LAST_ADDR(LAST), .SLEW_MAX(SLEW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .live_sel(live_sel), .live_x(live_x), .live_y(live_y), .live_z(live_z),
    .rom_address(rom_address), .rom_data_x(rom_data_x), .rom_data_y(rom_data_y),
    .rom_data_z(rom_data_z), .servo_x(servo_x), .servo_y(servo_y), .servo_z(servo_z),
    .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: playback described as "running / waiting / slewing / advancing".
  int m_cnt, m_addr, m_wait;
  int m_pos [3];
  int m_tgt [3];
  int m_servo [3];
  bit m_run, m_slewing, m_done;

  task automatic model_reset();
    m_cnt = 0; m_addr = 0; m_wait = 0;
    m_run = 0; m_slewing = 0; m_done = 0;
    for (int c = 0; c < 3; c++) begin
      m_pos[c] = 'h80; m_tgt[c] = 'h80; m_servo[c] = 'h80;
    end
  endtask

  task automatic model_step();
    bit tick;
    bit all_eq;
    int d;
    tick  = (m_cnt == TDIV - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    m_servo[0] = live_sel ? int'(live_x) : m_pos[0];
    m_servo[1] = live_sel ? int'(live_y) : m_pos[1];
    m_servo[2] = live_sel ? int'(live_z) : m_pos[2];
    m_done = 0;
    if (!m_run) begin
      if (start && !stop) begin m_run = 1; m_wait = 2; end
    end else if (stop) begin
      m_run = 0; m_wait = 0; m_slewing = 0; m_addr = 0;
    end else if (m_wait == 2) begin
      m_wait = 1;
    end else if (m_wait == 1) begin
      for (int c = 0; c < 3; c++) m_tgt[c] = int'(rom[c][m_addr]);
      m_wait = 0; m_slewing = 1;
    end else if (m_slewing) begin
      if (tick) begin
        all_eq = 1;
        for (int c = 0; c < 3; c++) begin
          d = m_tgt[c] - m_pos[c];
          if (d > SLEW)  d = SLEW;
          if (d < -SLEW) d = -SLEW;
          m_pos[c] += d;
          if (m_pos[c] != m_tgt[c]) all_eq = 0;
        end
        if (all_eq) m_slewing = 0;
      end
    end else begin
      if (m_addr < LAST)  begin m_addr++; m_wait = 2; end
      else if (loop_en)   begin m_addr = 0; m_wait = 2; end
      else                begin m_addr = 0; m_run = 0; m_done = 1; end
    end
  endtask

  function automatic logic [57:0] dut_vec();
    return {servo_x, servo_y, servo_z, rom_address, busy, done};
  endfunction

  function automatic logic [57:0] model_vec();
    return {16'(m_servo[0]), 16'(m_servo[1]), 16'(m_servo[2]), 8'(m_addr), m_run, m_done};
  endfunction

  task automatic check(input string name, input logic [57:0] act, input logic [57:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s t=%0t: got sx=%h sy=%h sz=%h addr=%h busy=%b done=%b, expected sx=%h sy=%h sz=%h addr=%h busy=%b done=%b",
                 name, $time, act[57:42], act[41:26], act[25:10], act[9:2], act[1], act[0],
                 exp[57:42], exp[41:26], exp[25:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step();
    #1;
    check("cycle", dut_vec(), model_vec());
  endtask

  typedef struct {
    bit          start, stop, loop_en, live_sel;
    logic [15:0] lx;
    int          cyc;
    logic [15:0] sx, sy, sz;
    logic [7:0]  addr;
    bit          busy, done;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rom[0][0] = 8'h84; rom[1][0] = 8'h80; rom[2][0] = 8'h7C;
    for (int a = 1; a <= LAST; a++) begin
      rom[0][a] = 8'h90; rom[1][a] = 8'h80; rom[2][a] = 8'h7C;
    end
    //          st st lp lv  live     cyc  sx      sy      sz      addr  b  d
    vecs[0]  = '{1, 0, 0, 0, 16'h0,    1, 16'h80, 16'h80, 16'h80, 8'd0, 1, 0};
    vecs[1]  = '{0, 0, 0, 0, 16'h0,    9, 16'h80, 16'h80, 16'h80, 8'd0, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 16'h0,    1, 16'h84, 16'h80, 16'h7C, 8'd1, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 16'h0,   10, 16'h88, 16'h80, 16'h7C, 8'd1, 1, 0};
    vecs[4]  = '{0, 0, 0, 0, 16'h0,   10, 16'h8C, 16'h80, 16'h7C, 8'd1, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 16'h0,   10, 16'h90, 16'h80, 16'h7C, 8'd2, 1, 0};
    vecs[6]  = '{0, 0, 0, 0, 16'h0,   10, 16'h90, 16'h80, 16'h7C, 8'd3, 1, 0};
    vecs[7]  = '{0, 0, 0, 0, 16'h0,    9, 16'h90, 16'h80, 16'h7C, 8'd3, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 16'h0,    1, 16'h90, 16'h80, 16'h7C, 8'd0, 0, 1};
    vecs[9]  = '{0, 0, 0, 0, 16'h0,    1, 16'h90, 16'h80, 16'h7C, 8'd0, 0, 0};
    vecs[10] = '{1, 0, 1, 0, 16'h0,    1, 16'h90, 16'h80, 16'h7C, 8'd0, 1, 0};
    vecs[11] = '{0, 0, 1, 0, 16'h0,   18, 16'h88, 16'h80, 16'h7C, 8'd0, 1, 0};
    vecs[12] = '{0, 0, 1, 0, 16'h0,   59, 16'h90, 16'h80, 16'h7C, 8'd3, 1, 0};
    vecs[13] = '{0, 0, 1, 0, 16'h0,    1, 16'h90, 16'h80, 16'h7C, 8'd0, 1, 0};
    vecs[14] = '{0, 0, 1, 0, 16'h0,   19, 16'h8C, 16'h80, 16'h7C, 8'd0, 1, 0};
    vecs[15] = '{0, 0, 1, 0, 16'h0,    1, 16'h88, 16'h80, 16'h7C, 8'd0, 1, 0};
    vecs[16] = '{0, 1, 1, 0, 16'h0,    1, 16'h88, 16'h80, 16'h7C, 8'd0, 0, 0};
    vecs[17] = '{0, 0, 1, 1, 16'h1234, 1, 16'h1234, 16'hEDCB, 16'h1235, 8'd0, 0, 0};
    vecs[18] = '{0, 0, 1, 0, 16'h0,    1, 16'h88, 16'h80, 16'h7C, 8'd0, 0, 0};
    vecs[19] = '{1, 0, 1, 0, 16'h0,    1, 16'h88, 16'h80, 16'h7C, 8'd0, 1, 0};

    model_reset();
    #20;
    check("reset_state", dut_vec(), {16'h0080, 16'h0080, 16'h0080, 8'h00, 1'b0, 1'b0});
    #3;
    rst_n = 1'b1;

    for (int v = 0; v < 20; v++) begin
      start = vecs[v].start; stop = vecs[v].stop;
      loop_en = vecs[v].loop_en; live_sel = vecs[v].live_sel;
      live_x = vecs[v].lx; live_y = ~vecs[v].lx; live_z = vecs[v].lx + 16'd1;
      repeat (vecs[v].cyc) step_cycle();
      check($sformatf("vec%0d", v), dut_vec(),
            {vecs[v].sx, vecs[v].sy, vecs[v].sz, vecs[v].addr, vecs[v].busy, vecs[v].done});
    end

    // Start held while busy must be ignored; then abort and load fresh random trajectories.
    start = 1'b1; live_sel = 1'b0;
    repeat (25) step_cycle();
    start = 1'b0; stop = 1'b1;
    step_cycle();
    stop = 1'b0;
    for (int c = 0; c < 3; c++)
      for (int a = 0; a <= LAST; a++)
        rom[c][a] = 8'($urandom_range(8'h60, 8'hA0));

    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 199) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 49) == 0)  live_sel = ~live_sel;
      live_x = 16'($urandom); live_y = 16'($urandom); live_z = 16'($urandom);
      step_cycle();
    end

    // Asynchronous reset mid-run must clear outputs without waiting for a clock edge.
    start = 1'b1; loop_en = 1'b1; live_sel = 1'b0;
    repeat (30) step_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_vec(), {16'h0080, 16'h0080, 16'h0080, 8'h00, 1'b0, 1'b0});
    #3;
    model_reset();
    rst_n = 1'b1;
    loop_en = 1'b0;
    repeat (200) step_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
